// File: rtl/resp_pkg.sv
// Shared types and helpers for the fixed-latency request/response responder.
package resp_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam int LATENCY_MAX = 16;
   localparam int PAR_W_MAX   = 64;

   // Callers zero-extend narrower payloads; zero bits do not change the result.
   function automatic logic parity(input logic [PAR_W_MAX-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/lat_pipe_stage.sv
// One delay stage: a valid bit plus payload and parity, cleared by flush.
module lat_pipe_stage #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          vld_in,
   input  logic [DW-1:0] data_in,
   input  logic          par_in,
   output logic          vld,
   output logic [DW-1:0] data,
   output logic          par
);

   // Payload only moves with a live valid, so the final stage holds the last
   // delivered response while no new one is arriving.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld  <= 1'b0;
         data <= '0;
         par  <= 1'b0;
      end else begin
         vld <= vld_in & ~flush;
         if (vld_in && !flush) begin
            data <= data_in;
            par  <= par_in;
         end
      end
   end

endmodule

// File: rtl/fixed_latency_responder.sv
// Echoes each accepted request payload (with even parity) exactly LATENCY clocks later.
module fixed_latency_responder
   import resp_pkg::*;
#(
   parameter int LATENCY = 2,
   parameter int DW      = 8,
   parameter int CNT_W   = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic                           flush,
   input  logic                           req_vld,
   input  logic [DW-1:0]                  req_data,
   output logic                           rsp_vld,
   output logic [DW-1:0]                  rsp_data,
   output logic                           rsp_par,
   output logic [$clog2(LATENCY+1)-1:0]   inflight,
   output logic                           idle,
   output logic [CNT_W-1:0]               req_cnt
);

   localparam int IW = $clog2(LATENCY+1);

   if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
      $error("fixed_latency_responder: LATENCY %0d outside 1..%0d", LATENCY, LATENCY_MAX);
   end
   if (DW < 1 || DW > PAR_W_MAX) begin : g_bad_dw
      $error("fixed_latency_responder: DW %0d outside 1..%0d", DW, PAR_W_MAX);
   end

   logic                          accept;
   logic [LATENCY-1:0]            vld_pipe;
   logic [LATENCY-1:0][DW-1:0]    data_pipe;
   logic [LATENCY-1:0]            par_pipe;
   logic [IW-1:0]                 inflight_nxt;
   state_t                        state, state_nxt;

   // Flush wins over a same-cycle request.
   assign accept = req_vld & en & ~flush;

   for (genvar i = 0; i < LATENCY; i++) begin : g_stage
      if (i == 0) begin : g_head
         lat_pipe_stage #(.DW(DW)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .vld_in  (accept),
            .data_in (req_data),
            .par_in  (parity(PAR_W_MAX'(req_data))),
            .vld     (vld_pipe[i]),
            .data    (data_pipe[i]),
            .par     (par_pipe[i])
         );
      end else begin : g_body
         lat_pipe_stage #(.DW(DW)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .vld_in  (vld_pipe[i-1]),
            .data_in (data_pipe[i-1]),
            .par_in  (par_pipe[i-1]),
            .vld     (vld_pipe[i]),
            .data    (data_pipe[i]),
            .par     (par_pipe[i])
         );
      end
   end

   assign rsp_vld  = vld_pipe[LATENCY-1];
   assign rsp_data = data_pipe[LATENCY-1];
   assign rsp_par  = par_pipe[LATENCY-1];

   // Up/down count tracks popcount(vld_pipe) without an adder tree.
   always_comb begin
      inflight_nxt = inflight;
      if (flush)
         inflight_nxt = '0;
      else
         inflight_nxt = inflight + IW'(accept) - IW'(rsp_vld);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ACTIVE;
         ACTIVE:  if (flush || inflight_nxt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         inflight <= '0;
         req_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= inflight_nxt;
         if (accept && req_cnt != '1)
            req_cnt <= req_cnt + 1'b1;
      end
   end

   assign idle = (state == IDLE);

endmodule

// File: tb/tb_fixed_latency_responder.sv
// Bench: vector table, directed corner sequences, and randomized traffic vs a queue model.
module tb_fixed_latency_responder;

   localparam int LAT = 2;
   localparam int DW  = 8;
   localparam int CW  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          en, flush, req_vld;
   logic [DW-1:0] req_data;
   logic          rsp_vld;
   logic [DW-1:0] rsp_data;
   logic          rsp_par;
   logic [1:0]    inflight;
   logic          idle;
   logic [CW-1:0] req_cnt;

   fixed_latency_responder #(.LATENCY(LAT), .DW(DW), .CNT_W(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .flush    (flush),
      .req_vld  (req_vld),
      .req_data (req_data),
      .rsp_vld  (rsp_vld),
      .rsp_data (rsp_data),
      .rsp_par  (rsp_par),
      .inflight (inflight),
      .idle     (idle),
      .req_cnt  (req_cnt)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int n_rsp = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a list of pending responses, each with the cycle it is due.
   typedef struct {
      int            due;
      logic [DW-1:0] d;
   } pend_t;

   pend_t         q[$];
   int            cyc;
   logic          m_vld;
   logic [DW-1:0] m_data;
   int            m_cnt;

   task automatic model_reset();
      q.delete();
      cyc    = 0;
      m_vld  = 1'b0;
      m_data = '0;
      m_cnt  = 0;
   endtask

   task automatic model_edge(input logic e, input logic f, input logic r, input logic [DW-1:0] d);
      pend_t p;
      cyc++;
      if (f) q.delete();
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      if (!f && e && r) begin
         p.due = cyc + LAT - 1;
         p.d   = d;
         q.push_back(p);
         if (m_cnt != (1 << CW) - 1) m_cnt++;
      end
      m_vld = (q.size() > 0 && q[0].due == cyc);
      if (m_vld) m_data = q[0].d;
   endtask

   task automatic step(input logic e, input logic f, input logic r, input logic [DW-1:0] d);
      en = e; flush = f; req_vld = r; req_data = d;
      @(posedge clk); #1;
      model_edge(e, f, r, d);
      if (rsp_vld) n_rsp++;
      chk("m_rsp_vld",  32'(rsp_vld),  32'(m_vld));
      chk("m_rsp_data", 32'(rsp_data), 32'(m_data));
      chk("m_rsp_par",  32'(rsp_par),  32'(^m_data));
      chk("m_inflight", 32'(inflight), 32'(q.size()));
      chk("m_idle",     32'(idle),     32'(q.size() == 0));
      chk("m_req_cnt",  32'(req_cnt),  32'(m_cnt));
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_rsp_vld"},  32'(rsp_vld),  32'd0);
      chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
      chk({tag, "_rsp_par"},  32'(rsp_par),  32'd0);
      chk({tag, "_inflight"}, 32'(inflight), 32'd0);
      chk({tag, "_idle"},     32'(idle),     32'd1);
      chk({tag, "_req_cnt"},  32'(req_cnt),  32'd0);
   endtask

   task automatic do_reset();
      en = 1'b0; flush = 1'b0; req_vld = 1'b0; req_data = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("rst");
      rst = 1'b0;
      model_reset();
   endtask

   typedef struct {
      logic          en, fl, rq;
      logic [DW-1:0] d;
      logic          vld;
      logic [DW-1:0] rd;
      logic          par;
      logic [1:0]    infl;
      logic          idl;
      logic [CW-1:0] cnt;
   } vec_t;

   vec_t tbl[17];

   initial begin
      // single request, back-to-back, en gating, flush with same-cycle request
      tbl[0]  = '{1'b1,1'b0,1'b1,8'hA5, 1'b0,8'h00,1'b0,2'd1,1'b0,4'd1};
      tbl[1]  = '{1'b1,1'b0,1'b0,8'h00, 1'b1,8'hA5,1'b0,2'd1,1'b0,4'd1};
      tbl[2]  = '{1'b1,1'b0,1'b0,8'h00, 1'b0,8'hA5,1'b0,2'd0,1'b1,4'd1};
      tbl[3]  = '{1'b1,1'b0,1'b1,8'h01, 1'b0,8'hA5,1'b0,2'd1,1'b0,4'd2};
      tbl[4]  = '{1'b1,1'b0,1'b1,8'h02, 1'b1,8'h01,1'b1,2'd2,1'b0,4'd3};
      tbl[5]  = '{1'b1,1'b0,1'b1,8'h03, 1'b1,8'h02,1'b1,2'd2,1'b0,4'd4};
      tbl[6]  = '{1'b1,1'b0,1'b0,8'h00, 1'b1,8'h03,1'b0,2'd1,1'b0,4'd4};
      tbl[7]  = '{1'b1,1'b0,1'b0,8'h00, 1'b0,8'h03,1'b0,2'd0,1'b1,4'd4};
      tbl[8]  = '{1'b0,1'b0,1'b1,8'h55, 1'b0,8'h03,1'b0,2'd0,1'b1,4'd4};
      tbl[9]  = '{1'b1,1'b0,1'b1,8'h66, 1'b0,8'h03,1'b0,2'd1,1'b0,4'd5};
      tbl[10] = '{1'b0,1'b0,1'b1,8'h77, 1'b1,8'h66,1'b0,2'd1,1'b0,4'd5};
      tbl[11] = '{1'b1,1'b0,1'b0,8'h00, 1'b0,8'h66,1'b0,2'd0,1'b1,4'd5};
      tbl[12] = '{1'b1,1'b0,1'b1,8'h10, 1'b0,8'h66,1'b0,2'd1,1'b0,4'd6};
      tbl[13] = '{1'b1,1'b0,1'b1,8'h11, 1'b1,8'h10,1'b1,2'd2,1'b0,4'd7};
      tbl[14] = '{1'b1,1'b1,1'b1,8'h12, 1'b0,8'h10,1'b1,2'd0,1'b1,4'd7};
      tbl[15] = '{1'b1,1'b0,1'b0,8'h00, 1'b0,8'h10,1'b1,2'd0,1'b1,4'd7};
      tbl[16] = '{1'b1,1'b0,1'b0,8'h00, 1'b0,8'h10,1'b1,2'd0,1'b1,4'd7};

      do_reset();
      for (int i = 0; i < 17; i++) begin
         en = tbl[i].en; flush = tbl[i].fl; req_vld = tbl[i].rq; req_data = tbl[i].d;
         @(posedge clk); #1;
         chk($sformatf("t%0d_rsp_vld", i),  32'(rsp_vld),  32'(tbl[i].vld));
         chk($sformatf("t%0d_rsp_data", i), 32'(rsp_data), 32'(tbl[i].rd));
         chk($sformatf("t%0d_rsp_par", i),  32'(rsp_par),  32'(tbl[i].par));
         chk($sformatf("t%0d_inflight", i), 32'(inflight), 32'(tbl[i].infl));
         chk($sformatf("t%0d_idle", i),     32'(idle),     32'(tbl[i].idl));
         chk($sformatf("t%0d_req_cnt", i),  32'(req_cnt),  32'(tbl[i].cnt));
      end

      // saturation: 20 continuous requests, counter sticks, all responses delivered
      do_reset();
      n_rsp = 0;
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 8'(i + 8'h30));
      repeat (LAT + 1) step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("sat_req_cnt", 32'(req_cnt), 32'hF);
      chk("sat_rsp_count", 32'(n_rsp), 32'd20);

      // async reset between accept and response: response is dropped
      do_reset();
      step(1'b1, 1'b0, 1'b1, 8'hC3);
      en = 1'b0; req_vld = 1'b0;
      #3 rst = 1'b1;
      #1;
      check_reset_vals("amid");
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00);

      // randomized traffic against the pending-list model
      do_reset();
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 9) < 8), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 9) < 7), 8'($urandom));
      repeat (LAT + 1) step(1'b1, 1'b0, 1'b0, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
